// File: rtl/reconfig_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reconfig_pkg
// Description : Shared types and constants for the remote-update sequencer:
//               state encoding, retry counter width, default timing values
//               and the saturating retry increment.
// Revision    : 1.0 - initial release
// ============================================================================
package reconfig_pkg;

    // Sequencer states, explicitly encoded in 3 bits
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        COUNT = 3'd1,
        SETUP = 3'd2,
        FIRE  = 3'd3,
        WAIT  = 3'd4,
        FAULT = 3'd5
    } state_t;

    // Width of the retry counter (saturates at 7)
    localparam int RETRY_W = 3;

    // Default timing values used as parameter defaults by the top level
    localparam int DEF_SETUP_CYCLES = 4;
    localparam int DEF_PULSE_CYCLES = 8;
    localparam int DEF_ERR_WINDOW   = 1024;
    localparam int DEF_MAX_RETRY    = 2;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [RETRY_W-1:0] retry_inc(input logic [RETRY_W-1:0] v);
        return (v == {RETRY_W{1'b1}}) ? v : v + RETRY_W'(1);
    endfunction

endpackage : reconfig_pkg
`default_nettype wire

// File: rtl/reconfig_sync2.sv
`default_nettype none
// ============================================================================
// Module      : reconfig_sync2
// Description : Two-flop synchroniser for a single asynchronous level,
//               asynchronous active-low reset, resets to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module reconfig_sync2 (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    // Two back-to-back flops; only r_sync is safe to use downstream
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule : reconfig_sync2
`default_nettype wire

// File: rtl/reconfig_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : reconfig_sequencer
// Description : Remote-update sequencer driving the internal reconfiguration
//               primitive (cfg_CBSEL/cfg_ENA/cfg_CONFIG/cfg_ERROR). Auto
//               countdown or manual trigger, setup/pulse timing, retries on
//               failure, fault reporting.
//               Optional build macro: RECONFIG_FALLBACK_EN - after retries
//               are exhausted, one extra attempt with FALLBACK_IMAGE.
// Revision    : 1.0 - initial release
// ============================================================================
module reconfig_sequencer
    import reconfig_pkg::*;
#(
    parameter int CBSEL_WIDTH    = 2,
    parameter int CNT_WIDTH      = 24,
    parameter int DEFAULT_IMAGE  = 2,
    parameter int SETUP_CYCLES   = DEF_SETUP_CYCLES,
    parameter int PULSE_CYCLES   = DEF_PULSE_CYCLES,
    parameter int ERR_WINDOW     = DEF_ERR_WINDOW,
    parameter int MAX_RETRY      = DEF_MAX_RETRY,
    parameter int FALLBACK_IMAGE = 0
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   auto_en,
    input  logic [CNT_WIDTH-1:0]   delay_cycles,
    input  logic                   start,
    input  logic [CBSEL_WIDTH-1:0] image_sel,
    input  logic                   clear_fault,
    input  logic                   cfg_ERROR,
    output logic [CBSEL_WIDTH-1:0] cfg_CBSEL,
    output logic                   cfg_ENA,
    output logic                   cfg_CONFIG,
    output logic                   busy,
    output logic                   fault,
    output logic [RETRY_W-1:0]     retry_count,
    output logic                   cfg_ERROR_sync
);

`ifdef RECONFIG_FALLBACK_EN
    localparam logic c_fallback_en = 1'b1;
`else
    localparam logic c_fallback_en = 1'b0;
`endif

    // Last timer value of each timed state (the state lasts value+1 cycles)
    localparam logic [CNT_WIDTH-1:0]   c_setup_last = CNT_WIDTH'(SETUP_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0]   c_pulse_last = CNT_WIDTH'(PULSE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0]   c_win_last   = CNT_WIDTH'(ERR_WINDOW - 1);
    localparam logic [RETRY_W-1:0]     c_max_retry  = RETRY_W'(MAX_RETRY);
    localparam logic [CBSEL_WIDTH-1:0] c_def_image  = CBSEL_WIDTH'(DEFAULT_IMAGE);
    localparam logic [CBSEL_WIDTH-1:0] c_fb_image   = CBSEL_WIDTH'(FALLBACK_IMAGE);

    state_t                 r_state;
    state_t                 w_next;
    logic [CNT_WIDTH-1:0]   r_timer;
    logic [CNT_WIDTH-1:0]   w_timer_next;
    logic [RETRY_W-1:0]     r_retry;
    logic [RETRY_W-1:0]     w_retry_next;
    logic [RETRY_W-1:0]     w_retry_inc;
    logic [CBSEL_WIDTH-1:0] r_image;
    logic [CBSEL_WIDTH-1:0] w_image_next;
    logic                   r_fallback;
    logic                   w_fallback_next;
    logic [CNT_WIDTH-1:0]   w_delay_last;
    logic                   w_err_sync;
    logic                   r_ena;
    logic                   r_config;
    logic                   r_busy;
    logic                   r_fault;

    reconfig_sync2 u_err_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (cfg_ERROR),
        .q    (w_err_sync)
    );

    // A zero delay behaves as a one-cycle countdown
    assign w_delay_last = (delay_cycles == '0) ? '0 : delay_cycles - CNT_WIDTH'(1);
    assign w_retry_inc  = retry_inc(r_retry);

    // Next-state, image latch and retry bookkeeping
    always_comb begin
        w_next          = r_state;
        w_retry_next    = r_retry;
        w_image_next    = r_image;
        w_fallback_next = r_fallback;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next          = SETUP;
                    w_image_next    = image_sel;
                    w_retry_next    = '0;
                    w_fallback_next = 1'b0;
                end else if (auto_en) begin
                    w_next = COUNT;
                end
            end
            COUNT: begin
                // start beats expiry; disabling auto beats expiry
                if (start) begin
                    w_next          = SETUP;
                    w_image_next    = image_sel;
                    w_retry_next    = '0;
                    w_fallback_next = 1'b0;
                end else if (!auto_en) begin
                    w_next = IDLE;
                end else if (r_timer >= w_delay_last) begin
                    w_next          = SETUP;
                    w_image_next    = c_def_image;
                    w_retry_next    = '0;
                    w_fallback_next = 1'b0;
                end
            end
            SETUP: begin
                if (r_timer == c_setup_last) w_next = FIRE;
            end
            FIRE: begin
                if (r_timer == c_pulse_last) w_next = WAIT;
            end
            WAIT: begin
                // Reaching here means the device did not reload: an error or
                // a silent window both count as a failed attempt
                if (w_err_sync || (r_timer == c_win_last)) begin
                    w_retry_next = w_retry_inc;
                    if (w_retry_inc < c_max_retry) begin
                        w_next = SETUP;
                    end else if (c_fallback_en && !r_fallback) begin
                        w_next          = SETUP;
                        w_image_next    = c_fb_image;
                        w_fallback_next = 1'b1;
                    end else begin
                        w_next = FAULT;
                    end
                end
            end
            FAULT: begin
                if (clear_fault) begin
                    w_next       = IDLE;
                    w_retry_next = '0;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Shared timer restarts on every state entry and idles at zero
    always_comb begin
        w_timer_next = r_timer + CNT_WIDTH'(1);
        if ((w_next != r_state) || (w_next == IDLE) || (w_next == FAULT)) begin
            w_timer_next = '0;
        end
    end

    // State, timer and sequence registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= IDLE;
            r_timer    <= '0;
            r_retry    <= '0;
            r_image    <= c_def_image;
            r_fallback <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_timer    <= w_timer_next;
            r_retry    <= w_retry_next;
            r_image    <= w_image_next;
            r_fallback <= w_fallback_next;
        end
    end

    // Outputs registered from the next state so they align with r_state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ena    <= 1'b0;
            r_config <= 1'b0;
            r_busy   <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            r_ena    <= (w_next == SETUP) || (w_next == FIRE) || (w_next == WAIT);
            r_config <= (w_next == FIRE);
            r_busy   <= (w_next != IDLE) && (w_next != FAULT);
            r_fault  <= (w_next == FAULT);
        end
    end

    assign cfg_CBSEL      = r_image;
    assign cfg_ENA        = r_ena;
    assign cfg_CONFIG     = r_config;
    assign busy           = r_busy;
    assign fault          = r_fault;
    assign retry_count    = r_retry;
    assign cfg_ERROR_sync = w_err_sync;

endmodule : reconfig_sequencer
`default_nettype wire

// File: tb/tb_reconfig_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reconfig_sequencer
// Description : Self-checking bench for reconfig_sequencer: a table of
//               per-step stimulus and expected outputs, plus hand-written
//               sequences for override, expiry, live delay and async reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reconfig_sequencer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        auto_en;
    logic [23:0] delay_cycles;
    logic        start;
    logic [1:0]  image_sel;
    logic        clear_fault;
    logic        cfg_ERROR;
    logic [1:0]  cfg_CBSEL;
    logic        cfg_ENA;
    logic        cfg_CONFIG;
    logic        busy;
    logic        fault;
    logic [2:0]  retry_count;
    logic        cfg_ERROR_sync;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        a;
        logic [23:0] d;
        logic        s;
        logic [1:0]  im;
        logic        c;
        logic        e;
        int          n;
        logic [1:0]  cb;
        logic        en;
        logic        cf;
        logic        bz;
        logic        ft;
        logic [2:0]  rc;
    } vec_t;

    vec_t vq[$];

    reconfig_sequencer #(
        .CBSEL_WIDTH    (2),
        .CNT_WIDTH      (24),
        .DEFAULT_IMAGE  (2),
        .SETUP_CYCLES   (4),
        .PULSE_CYCLES   (8),
        .ERR_WINDOW     (16),
        .MAX_RETRY      (2),
        .FALLBACK_IMAGE (0)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .auto_en        (auto_en),
        .delay_cycles   (delay_cycles),
        .start          (start),
        .image_sel      (image_sel),
        .clear_fault    (clear_fault),
        .cfg_ERROR      (cfg_ERROR),
        .cfg_CBSEL      (cfg_CBSEL),
        .cfg_ENA        (cfg_ENA),
        .cfg_CONFIG     (cfg_CONFIG),
        .busy           (busy),
        .fault          (fault),
        .retry_count    (retry_count),
        .cfg_ERROR_sync (cfg_ERROR_sync)
    );

    always #5 clk = ~clk;

    // Outputs packed as {cbsel, ena, config, busy, fault, retry}
    function automatic logic [8:0] pack(input logic [1:0] cb, input logic en,
                                        input logic cf, input logic bz,
                                        input logic ft, input logic [2:0] rc);
        return {cb, en, cf, bz, ft, rc};
    endfunction

    task automatic check(input string nm, input logic [8:0] exp);
        logic [8:0] act;
        act = pack(cfg_CBSEL, cfg_ENA, cfg_CONFIG, busy, fault, retry_count);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got cb=%0d ena=%b cfg=%b busy=%b flt=%b rc=%0d, want cb=%0d ena=%b cfg=%b busy=%b flt=%b rc=%0d",
                     nm, act[8:7], act[6], act[5], act[4], act[3], act[2:0],
                     exp[8:7], exp[6], exp[5], exp[4], exp[3], exp[2:0]);
        end
    endtask

    task automatic check_bit(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    // Advance n rising edges, ending on a falling edge
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic idle_inputs();
        auto_en      = 1'b0;
        delay_cycles = 24'd0;
        start        = 1'b0;
        image_sel    = 2'd0;
        clear_fault  = 1'b0;
        cfg_ERROR    = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rstn = 1'b0;
        tick(2);
        rstn = 1'b1;
        tick(1);
    endtask

    task automatic add(input logic a, input logic [23:0] d, input logic s,
                       input logic [1:0] im, input logic c, input logic e,
                       input int n, input logic [1:0] cb, input logic en,
                       input logic cf, input logic bz, input logic ft,
                       input logic [2:0] rc);
        vec_t v;
        v.a = a; v.d = d; v.s = s; v.im = im; v.c = c; v.e = e; v.n = n;
        v.cb = cb; v.en = en; v.cf = cf; v.bz = bz; v.ft = ft; v.rc = rc;
        vq.push_back(v);
    endtask

    initial begin
        // Table: a, delay, start, img, clr, err, cycles | cb ena cfg busy flt rc
        add(1, 10, 0, 0, 0, 0, 10,  2, 0, 0, 1, 0, 0); // still counting
        add(1, 10, 0, 0, 0, 0, 1,   2, 1, 0, 1, 0, 0); // expiry -> SETUP
        add(0, 10, 0, 0, 0, 0, 3,   2, 1, 0, 1, 0, 0); // SETUP held 4 cycles
        add(0, 10, 0, 0, 0, 0, 1,   2, 1, 1, 1, 0, 0); // FIRE
        add(0, 10, 0, 0, 0, 0, 7,   2, 1, 1, 1, 0, 0); // pulse still high
        add(0, 10, 0, 0, 0, 0, 1,   2, 1, 0, 1, 0, 0); // WAIT after 8
        add(0, 10, 0, 0, 0, 1, 3,   2, 1, 0, 1, 0, 1); // error -> retry
        add(0, 10, 0, 0, 0, 0, 4,   2, 1, 1, 1, 0, 1); // second FIRE
        add(0, 10, 0, 0, 0, 0, 8,   2, 1, 0, 1, 0, 1); // second WAIT
        add(0, 10, 0, 0, 0, 1, 3,   2, 0, 0, 0, 1, 2); // error -> FAULT
        add(0, 10, 1, 3, 0, 0, 1,   2, 0, 0, 0, 1, 2); // start ignored in FAULT
        add(0, 10, 0, 0, 0, 0, 4,   2, 0, 0, 0, 1, 2); // FAULT holds
        add(0, 10, 0, 0, 1, 0, 1,   2, 0, 0, 0, 0, 0); // clear -> IDLE
        add(0, 10, 1, 1, 0, 0, 1,   1, 1, 0, 1, 0, 0); // manual, image 1
        add(0, 10, 0, 0, 0, 0, 12,  1, 1, 0, 1, 0, 0); // WAIT
        add(0, 10, 0, 0, 0, 0, 15,  1, 1, 0, 1, 0, 0); // window not yet over
        add(0, 10, 0, 0, 0, 0, 1,   1, 1, 0, 1, 0, 1); // timeout -> retry
        add(0, 10, 0, 0, 0, 0, 12,  1, 1, 0, 1, 0, 1); // WAIT again
`ifdef RECONFIG_FALLBACK_EN
        add(0, 10, 0, 0, 0, 0, 16,  0, 1, 0, 1, 0, 2); // fallback SETUP
        add(0, 10, 0, 0, 0, 0, 12,  0, 1, 0, 1, 0, 2); // fallback WAIT
        add(0, 10, 0, 0, 0, 0, 16,  0, 0, 0, 0, 1, 3); // fallback fails
        add(0, 10, 0, 0, 1, 0, 1,   0, 0, 0, 0, 0, 0); // clear
`else
        add(0, 10, 0, 0, 0, 0, 16,  1, 0, 0, 0, 1, 2); // second timeout
        add(0, 10, 0, 0, 1, 0, 1,   1, 0, 0, 0, 0, 0); // clear
`endif

        idle_inputs();
        rstn = 1'b0;
        tick(2);
        check("reset_state", pack(2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0));
        rstn = 1'b1;
        tick(1);
        check("idle_after_reset", pack(2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0));

        for (int i = 0; i < vq.size(); i++) begin
            auto_en      = vq[i].a;
            delay_cycles = vq[i].d;
            start        = vq[i].s;
            image_sel    = vq[i].im;
            clear_fault  = vq[i].c;
            cfg_ERROR    = vq[i].e;
            tick(vq[i].n);
            check($sformatf("vec%0d", i),
                  pack(vq[i].cb, vq[i].en, vq[i].cf, vq[i].bz, vq[i].ft, vq[i].rc));
        end
        idle_inputs();

        // Manual override part-way through the countdown
        do_reset();
        auto_en = 1'b1; delay_cycles = 24'd10;
        tick(5);
        check("override_count", pack(2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0));
        start = 1'b1; image_sel = 2'd3;
        tick(1);
        start = 1'b0; auto_en = 1'b0;
        check("override_setup", pack(2'd3, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0));

        // start on the expiry cycle wins over the default image
        do_reset();
        auto_en = 1'b1; delay_cycles = 24'd10;
        tick(10);
        start = 1'b1; image_sel = 2'd3;
        tick(1);
        start = 1'b0; auto_en = 1'b0;
        check("expiry_start", pack(2'd3, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0));

        // Asynchronous reset during the pulse
        tick(4);
        check("fire_before_rst", pack(2'd3, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0));
        #2 rstn = 1'b0;
        #1;
        check_bit("rst_drops_config", cfg_CONFIG, 1'b0);
        check_bit("rst_drops_ena", cfg_ENA, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        tick(1);
        check("after_rst_idle", pack(2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0));

        // Lowering delay below the running count expires next cycle
        do_reset();
        auto_en = 1'b1; delay_cycles = 24'd10;
        tick(6);
        delay_cycles = 24'd3;
        tick(1);
        auto_en = 1'b0;
        check("live_delay", pack(2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0));

        // Zero delay acts as one cycle
        do_reset();
        auto_en = 1'b1; delay_cycles = 24'd0;
        tick(1);
        check("delay0_count", pack(2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0));
        tick(1);
        auto_en = 1'b0;
        check("delay0_setup", pack(2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0));

        // Dropping auto_en abandons the countdown
        do_reset();
        auto_en = 1'b1; delay_cycles = 24'd10;
        tick(3);
        auto_en = 1'b0;
        tick(1);
        check("auto_off_idle", pack(2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0));

        // Error synchroniser latency is two cycles
        cfg_ERROR = 1'b1;
        tick(1);
        check_bit("err_sync_1cyc", cfg_ERROR_sync, 1'b0);
        tick(1);
        check_bit("err_sync_2cyc", cfg_ERROR_sync, 1'b1);
        cfg_ERROR = 1'b0;
        tick(2);
        check_bit("err_sync_clear", cfg_ERROR_sync, 1'b0);
        check("err_idle_ignored", pack(2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_reconfig_sequencer
`default_nettype wire
